// File: rtl/fifo_stream_drain_pkg.sv
// Shared constants and width helpers for the FIFO-to-stream drain block.
// The beat counter width is derived from FRAME_LEN and is never narrower than one bit.
package fifo_stream_drain_pkg;

    localparam int BUF_DEPTH = 2;

    function automatic int beat_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/drain_buf2.sv
// Two-entry register buffer; rdata is the registered head entry, cnt the occupancy.
// The caller guarantees no write when full and no read when empty.
module drain_buf2
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  wr_idx;
    logic                  rd_idx;

    assign rdata = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr) begin
                mem[wr_idx] <= wdata;
                wr_idx      <= ~wr_idx;
            end
            if (rd) begin
                rd_idx <= ~rd_idx;
            end
            cnt <= cnt + {1'b0, wr} - {1'b0, rd};
        end
    end

endmodule

// File: rtl/synfifo.sv
// Single-clock FIFO with a registered read port: data_o updates one cycle after an accepted read.
// Writes are dropped when full and reads are ignored when empty.
module synfifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  do_wr;
    logic                  do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_wr = cs & wr_en & ~full;
    assign do_rd = cs & rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr   <= '0;
            rptr   <= '0;
            data_o <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                data_o <= mem[rptr[AW-1:0]];
                rptr   <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Pulls words from a registered-output FIFO into a valid/ready stream, 1 word/clk when the sink is ready.
// Read-to-m_data latency is 2 clk; reads stop once buffered plus in-flight words would exceed two.
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int                BCNT_W    = beat_width(FRAME_LEN);
    localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(FRAME_LEN - 1);

    logic [1:0]        cnt;
    logic              inflight;
    logic [BCNT_W-1:0] bcnt;
    logic              pop;
    logic [2:0]        occ;

    assign pop = m_valid & m_ready;

    // Occupancy after this edge; pop feeds it combinationally so a ready sink keeps reads flowing.
    assign occ        = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = rstn & en & ~fifo_empty & (occ < 3'd2);

    assign m_valid = (cnt != 2'd0);
    assign m_last  = m_valid & (bcnt == BEAT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight <= 1'b0;
            bcnt     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                bcnt <= (bcnt == BEAT_LAST) ? '0 : bcnt + 1'b1;
            end
        end
    end

    drain_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk  (clk),
        .rstn (rstn),
        .wr   (inflight),
        .wdata(fifo_data),
        .rd   (pop),
        .rdata(m_data),
        .cnt  (cnt)
    );

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain behind an 8-deep synfifo, FRAME_LEN=4.
module tb_fifo_stream_drain;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fifo_rstn;
    logic        en;
    logic        m_ready;
    logic        wr_en;
    logic [15:0] wdata;
    logic        fifo_empty;
    logic        fifo_full;
    logic [15:0] fifo_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    synfifo #(.DEPTH(8), .DATA_WIDTH(16)) u_fifo (
        .clk   (clk),
        .rstn  (fifo_rstn),
        .cs    (1'b1),
        .wr_en (wr_en),
        .rd_en (fifo_rd_en),
        .data_i(wdata),
        .data_o(fifo_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    fifo_stream_drain #(.DATA_WIDTH(16), .FRAME_LEN(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        rstn = 1'b0; fifo_rstn = 1'b0;
        en = 1'b0; m_ready = 1'b0; wr_en = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        out_cnt = 0;
        rstn = 1'b1; fifo_rstn = 1'b1;
    endtask

    task automatic prefill(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wdata = 16'(i + 1);
            sb.push_back(wdata);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clk);
            wr_en = 1'b0;
            c++;
        end
        chk("drain_complete", sb.size(), 0);
    endtask

    // Scoreboard monitor, plus hold-while-stalled and occupancy checks.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    always begin
        @(negedge clk);
        #2;
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            chk("cnt_le_2", dut.u_buf.cnt <= 2'd2, 1);
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none at %0t", m_data, $time);
                end else begin
                    logic [15:0] exp_w;
                    exp_w = sb.pop_front();
                    chk("sb_data", m_data, exp_w);
                    chk("sb_last", m_last, (out_cnt % 4) == 3);
                    out_cnt++;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    typedef struct {
        logic        ready;
        logic        en;
        logic        exp_rd;
        logic        exp_vld;
        logic [15:0] exp_dat;
        logic        exp_last;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int written;

        // Full-throughput drain of 8 prefetched words, cycle by cycle.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

        rstn = 1'b0; fifo_rstn = 1'b0;
        en = 1'b1; m_ready = 1'b1; wr_en = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);

        // Reset held on the drain while the FIFO fills and stays non-empty.
        fifo_rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = (i < 3);
            wdata = 16'(16'h00a0 + i);
            #1;
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_last", m_last, 0);
            chk("rst_data", m_data, 0);
        end
        chk("rst_fifo_nonempty", fifo_empty, 0);

        reset_all();
        prefill(8);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            en = vecs[k].en;
            m_ready = vecs[k].ready;
            #1;
            chk($sformatf("vec%0d_rd_en", k), fifo_rd_en, vecs[k].exp_rd);
            chk($sformatf("vec%0d_valid", k), m_valid, vecs[k].exp_vld);
            if (vecs[k].exp_vld) begin
                chk($sformatf("vec%0d_data", k), m_data, vecs[k].exp_dat);
                chk($sformatf("vec%0d_last", k), m_last, vecs[k].exp_last);
            end
        end
        wait_drain(20);

        // Backpressure: exactly two reads fill the buffer, head stays on word 1.
        reset_all();
        prefill(8);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            en = 1'b1;
            m_ready = 1'b0;
            #1;
            if (fifo_rd_en) pulses++;
            if (m_valid) chk("bp_head", m_data, 16'h0001);
        end
        chk("bp_pulses", pulses, 2);
        chk("bp_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_drain(100);

        // Empty FIFO: three words then no reads and no stale output.
        reset_all();
        en = 1'b1;
        m_ready = 1'b1;
        prefill(3);
        wait_drain(50);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("empty_flag", fifo_empty, 1);
            chk("empty_rd_en", fifo_rd_en, 0);
            chk("empty_valid", m_valid, 0);
        end

        // en drop right after a read: the in-flight word still lands.
        reset_all();
        prefill(4);
        @(negedge clk);
        wr_en = 1'b0;
        en = 1'b1;
        #1;
        chk("en_first_rd", fifo_rd_en, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en = 1'b0;
            #1;
            chk("en_off_rd", fifo_rd_en, 0);
        end
        chk("en_inflight_valid", m_valid, 1);
        chk("en_inflight_data", m_data, 16'h0001);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("en_off_drain_rd", fifo_rd_en, 0);
        end
        chk("en_off_idle", m_valid, 0);
        chk("en_off_remaining", sb.size(), 3);
        en = 1'b1;
        wait_drain(50);

        // Random ready and random writes, 1000 words.
        reset_all();
        written = 0;
        for (int c = 0; c < 30000 && !(written == 1000 && sb.size() == 0); c++) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            m_ready = $urandom_range(0, 1) == 1;
            if (written < 1000 && !fifo_full && $urandom_range(0, 1) == 1) begin
                wr_en = 1'b1;
                wdata = 16'($urandom);
                sb.push_back(wdata);
                written++;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        chk("rand_written", written, 1000);
        chk("rand_drained", sb.size(), 0);
        chk("rand_out_cnt", out_cnt, 1000);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
